ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 47 ++++
 rtl/ram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle for the shared-RAM arbiter: instruction-fetch port, data port
// and the single-ported RAM behind them. The arbiter is the slave side;
// requesters and the RAM model sit on the master side.
interface ram_arbiter_if;
  // instruction-fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  // data port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic        d_wack;
  logic [31:0] d_rdata;
  logic        d_err;

  // shared RAM
  logic        ram_write_enable;
  logic [31:0] ram_address;
  logic [31:0] ram_in;
  logic [31:0] ram_out;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  ram_out,
    output i_ready, i_rvalid, i_rdata, i_err,
    output d_ready, d_rvalid, d_wack, d_rdata, d_err,
    output ram_write_enable, ram_address, ram_in
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output ram_out,
    input  i_ready, i_rvalid, i_rdata, i_err,
    input  d_ready, d_rvalid, d_wack, d_rdata, d_err,
    input  ram_write_enable, ram_address, ram_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of one synchronous RAM. Each access takes three
// cycles (IDLE accept, ISSUE drives the RAM, WAIT collects ram_out) and the
// response pulse lands in the following IDLE cycle. Data wins ties unless the
// fetch port has already been passed over STARVE_LIMIT times in a row.
module ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          grant_i;
  logic          grant_d;
  logic          starved;
  logic [CW-1:0] starve_q;

  // access captured at acceptance
  logic          win_data_q;
  logic          we_q;
  logic          mis_q;

  // registered RAM drive
  logic          ram_we_q;
  logic [31:0]   ram_address_q;
  logic [31:0]   ram_in_q;

  // registered responses
  logic          i_rvalid_q;
  logic          i_err_q;
  logic [31:0]   i_rdata_q;
  logic          d_rvalid_q;
  logic          d_wack_q;
  logic          d_err_q;
  logic [31:0]   d_rdata_q;

  assign starved = (starve_q == CW'(STARVE_LIMIT));

  // Next-state and arbitration: ready goes only to the winner, only in IDLE
  // and never while reset is held.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset_n) begin
          if (bus.d_req && !(bus.i_req && starved)) begin
            grant_d = 1'b1;
          end else if (bus.i_req) begin
            grant_i = 1'b1;
          end
        end
        if (grant_i || grant_d) begin
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_i || !bus.i_req) begin
        starve_q <= '0;
      end else if (grant_d && !starved) begin
        starve_q <= starve_q + CW'(1);
      end
    end
  end

  // Latch the winning request, drive the RAM during ISSUE, and turn ram_out
  // into a one-cycle response when leaving WAIT. Misaligned accesses run the
  // same timeline but never write and answer with zero data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      win_data_q    <= 1'b0;
      we_q          <= 1'b0;
      mis_q         <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      i_rvalid_q    <= 1'b0;
      i_err_q       <= 1'b0;
      i_rdata_q     <= '0;
      d_rvalid_q    <= 1'b0;
      d_wack_q      <= 1'b0;
      d_err_q       <= 1'b0;
      d_rdata_q     <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_wack_q   <= 1'b0;
      d_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            win_data_q    <= 1'b0;
            we_q          <= 1'b0;
            mis_q         <= (bus.i_addr[1:0] != 2'b00);
            ram_we_q      <= 1'b0;
            ram_address_q <= bus.i_addr;
            ram_in_q      <= '0;
          end else if (grant_d) begin
            win_data_q    <= 1'b1;
            we_q          <= bus.d_we;
            mis_q         <= (bus.d_addr[1:0] != 2'b00);
            ram_we_q      <= bus.d_we && (bus.d_addr[1:0] == 2'b00);
            ram_address_q <= bus.d_addr;
            ram_in_q      <= bus.d_wdata;
          end
        end
        ISSUE: begin
          ram_we_q <= 1'b0;
        end
        WAIT: begin
          if (win_data_q) begin
            d_err_q <= mis_q;
            if (we_q) begin
              d_wack_q <= 1'b1;
            end else begin
              d_rvalid_q <= 1'b1;
            end
            if (mis_q) begin
              d_rdata_q <= '0;
            end else if (!we_q) begin
              d_rdata_q <= bus.ram_out;
            end
          end else begin
            i_rvalid_q <= 1'b1;
            i_err_q    <= mis_q;
            i_rdata_q  <= mis_q ? '0 : bus.ram_out;
          end
        end
        default: begin
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_ready  = grant_i;
  assign bus.d_ready  = grant_d;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_err    = i_err_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_wack   = d_wack_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = d_rdata_q;

  // The write strobe is qualified with reset_n so a reset landing during
  // ISSUE kills the write at the very edge the RAM would have sampled it.
  assign bus.ram_write_enable = ram_we_q && reset_n;
  assign bus.ram_address      = ram_address_q;
  assign bus.ram_in           = ram_in_q;

endmodule
